// File: rtl/fft_tile_loader.sv
// fft_tile_loader: buffers a row-major pixel stream into two ping-pong
// WIDTH x WIDTH tile banks and replays each full tile column by column
// to a 2D FFT. A tile is announced with a one-cycle 'next' pulse, and
// the columns follow on the next WIDTH cycles.
module fft_tile_loader #(
    parameter int WIDTH  = 4,
    parameter int DATA_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      fft_ready,
    output logic                      next,
    output logic [WIDTH*DATA_W-1:0]   out_data,
    output logic                      out_valid
);
    localparam int DEPTH = WIDTH * WIDTH;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(WIDTH);

    // Only power-of-two edges from 4 to 16 are supported; the address
    // concatenation {bank,row,col} below relies on WIDTH being 2**CW.
    generate
        if (!(WIDTH == 4 || WIDTH == 8 || WIDTH == 16)) begin : g_bad_width
            $fatal(1, "fft_tile_loader: WIDTH must be 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, START, STREAM} state_t;

    // Both banks share one array; the top address bit selects the bank.
    logic [DATA_W-1:0]        r_mem [0:2*DEPTH-1];
    logic [1:0]               r_full;
    logic                     r_wbank;
    logic                     r_rbank;
    logic [PW-1:0]            r_wptr;
    state_t                   r_state;
    logic [CW-1:0]            r_col;
    logic                     r_next;
    logic                     r_out_valid;
    logic [WIDTH*DATA_W-1:0]  r_out_data;

    logic                     w_wr;
    logic                     w_wr_last;
    logic                     w_rd_done;
    logic                     w_tile_ready;
    logic [1:0]               w_full_nxt;
    logic [CW-1:0]            w_rd_col;
    logic [WIDTH*DATA_W-1:0]  w_col_data;

    // The writer stalls purely on the registered full flag of its bank, so
    // a bank freed by the reader only reopens the input one cycle later.
    assign in_ready  = ~r_full[r_wbank];
    assign w_wr      = in_valid & in_ready;
    assign w_wr_last = w_wr & (r_wptr == PW'(DEPTH - 1));
    assign w_rd_done = (r_state == STREAM) && (r_col == CW'(WIDTH - 1));

    // A tile completing this cycle in the read bank is already usable, which
    // lets 'next' follow the last accepted sample by exactly one cycle.
    assign w_tile_ready = r_full[r_rbank] | (w_wr_last & (r_wbank == r_rbank));

    // Column loaded into the output register at the coming edge: column 0
    // when leaving START, otherwise the one after the column on display.
    assign w_rd_col = (r_state == STREAM) ? r_col + CW'(1) : '0;

    assign next      = r_next;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    // Gather one column of the read bank: lane i is row i.
    always_comb begin
        w_col_data = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_col_data[i*DATA_W +: DATA_W] = r_mem[{r_rbank, CW'(i), w_rd_col}];
        end
    end

    // Next full-flag state; set and clear can never hit the same bank since
    // the writer only fills an empty bank and the reader only drains a full one.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_last) w_full_nxt[r_wbank] = 1'b1;
        if (w_rd_done) w_full_nxt[r_rbank] = 1'b0;
    end

    // Sample storage; contents survive reset, only the flags are cleared.
    always_ff @(posedge clk) begin
        if (reset && w_wr) begin
            r_mem[{r_wbank, r_wptr}] <= in_data;
        end
    end

    // Write pointer walks the fill bank row-major and swaps bank on wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_wbank <= 1'b0;
        end else if (w_wr) begin
            if (w_wr_last) begin
                r_wptr  <= '0;
                r_wbank <= ~r_wbank;
            end else begin
                r_wptr  <= r_wptr + PW'(1);
            end
        end
    end

    // Bank full flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_full <= '0;
        end else begin
            r_full <= w_full_nxt;
        end
    end

    // Read FSM: announce a full tile, then stream its columns without pause.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_rbank     <= 1'b0;
            r_col       <= '0;
            r_next      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_next <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_tile_ready && fft_ready) begin
                        r_state <= START;
                        r_next  <= 1'b1;
                    end
                end
                START: begin
                    r_state     <= STREAM;
                    r_col       <= '0;
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_col_data;
                end
                STREAM: begin
                    if (w_rd_done) begin
                        r_state     <= IDLE;
                        r_rbank     <= ~r_rbank;
                        r_out_valid <= 1'b0;
                        r_out_data  <= '0;
                    end else begin
                        r_col      <= r_col + CW'(1);
                        r_out_data <= w_col_data;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_tile_loader.sv
// Bench for fft_tile_loader: cycle table for the basic tile, hand-written
// corner sequences, and a randomized run checked by a transposing scoreboard.
module tb_fft_tile_loader;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, fft_ready, in_ready, nxt, out_valid;
    logic [15:0]  in_data;
    logic [63:0]  out_data;
    logic         in_valid16, fft_ready16, in_ready16, nxt16, out_valid16;
    logic [15:0]  in_data16;
    logic [255:0] out_data16;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fft_tile_loader #(.WIDTH(4), .DATA_W(16)) dut4 (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .fft_ready(fft_ready), .next(nxt),
        .out_data(out_data), .out_valid(out_valid)
    );

    fft_tile_loader #(.WIDTH(16), .DATA_W(16)) dut16 (
        .clk(clk), .reset(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .in_data(in_data16), .fft_ready(fft_ready16), .next(nxt16),
        .out_data(out_data16), .out_valid(out_valid16)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: accepted samples are grouped into 16-sample tiles in
    // arrival order; each streamed column c must equal {t[c],t[4+c],t[8+c],t[12+c]}.
    logic [15:0] q_in[$];
    logic [15:0] tiles[$];
    int          col_i = 0;
    int          tiles_done = 0;
    int          cyc_n = 0;
    int          next_t[$];

    always @(negedge clk) begin
        cyc_n++;
        if (out_valid === 1'b1) begin
            if (tiles.size() < 16) begin
                chk("sb_col_without_tile", 1'b1, 1'b0);
            end else begin
                logic [63:0] e;
                for (int i = 0; i < 4; i++) e[i*16 +: 16] = tiles[i*4 + col_i];
                chk("sb_column", out_data, e);
                col_i++;
                if (col_i == 4) begin
                    col_i = 0;
                    for (int i = 0; i < 16; i++) void'(tiles.pop_front());
                    tiles_done++;
                end
            end
        end else begin
            chk("sb_idle_data_zero", out_data, 64'd0);
        end
        if (nxt === 1'b1) begin
            if (next_t.size() > 0)
                chk("sb_next_spacing_ge6", ((cyc_n - next_t[$]) >= 6), 1'b1);
            next_t.push_back(cyc_n);
        end
        if (rst_n === 1'b0) begin
            q_in.delete();
            tiles.delete();
            col_i = 0;
        end else if (in_valid === 1'b1 && in_ready === 1'b1) begin
            q_in.push_back(in_data);
            if (q_in.size() == 16) begin
                foreach (q_in[i]) tiles.push_back(q_in[i]);
                q_in.delete();
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        chk("rst_next", nxt, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 64'd0);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", in_ready, 1'b1);
    endtask

    task automatic wait_tiles(input int target, input string nm);
        for (int i = 0; i < 400 && tiles_done < target; i++) step();
        chk(nm, tiles_done, target);
    endtask

    typedef struct {
        logic        vld;
        logic        frdy;
        logic [15:0] din;
        logic        e_rdy;
        logic        e_next;
        logic        e_ovld;
        logic [63:0] e_out;
    } vec_t;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[23];
        int   n0, d0, acc, seen;
        logic [255:0] e16;

        for (int k = 0; k < 23; k++) begin
            tv[k].vld    = (k < 16);
            tv[k].frdy   = 1'b1;
            tv[k].din    = 16'(k);
            tv[k].e_rdy  = 1'b1;
            tv[k].e_next = (k == 16);
            tv[k].e_ovld = (k >= 17 && k <= 20);
            tv[k].e_out  = '0;
            if (tv[k].e_ovld)
                for (int i = 0; i < 4; i++) tv[k].e_out[i*16 +: 16] = 16'(4*i + k - 17);
        end

        rst_n = 1'b0; in_valid = 0; in_data = 0; fft_ready = 0;
        in_valid16 = 0; in_data16 = 0; fft_ready16 = 0;
        repeat (3) step();
        chk("rst_next", nxt, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 64'd0);
        rst_n = 1'b1;
        step();
        chk("rst_release_in_ready", in_ready, 1'b1);
        chk("rst_release_in_ready16", in_ready16, 1'b1);

        // Single tile 0..15 streamed straight through.
        for (int k = 0; k < 23; k++) begin
            in_valid = tv[k].vld; in_data = tv[k].din; fft_ready = tv[k].frdy;
            @(negedge clk);
            chk($sformatf("tbl_in_ready[%0d]", k), in_ready, tv[k].e_rdy);
            chk($sformatf("tbl_next[%0d]", k), nxt, tv[k].e_next);
            chk($sformatf("tbl_out_valid[%0d]", k), out_valid, tv[k].e_ovld);
            chk($sformatf("tbl_out_data[%0d]", k), out_data, tv[k].e_out);
            step();
        end

        // Two tiles buffered while the FFT is busy, then released.
        n0 = next_t.size(); d0 = tiles_done;
        fft_ready = 0;
        for (int k = 0; k < 32; k++) begin
            in_valid = 1; in_data = 16'(100 + k);
            step();
        end
        in_data = 16'd999;
        repeat (3) begin
            @(negedge clk);
            chk("both_full_in_ready", in_ready, 1'b0);
            step();
        end
        chk("both_full_no_next", next_t.size(), n0);
        fft_ready = 1;
        for (int j = 0; j < 8; j++) begin
            if (j == 6) in_valid = 0;
            @(negedge clk);
            chk($sformatf("drain_next[%0d]", j), nxt, (j == 1 || j == 7));
            chk($sformatf("drain_out_valid[%0d]", j), out_valid, (j >= 2 && j <= 5));
            chk($sformatf("drain_in_ready[%0d]", j), in_ready, (j >= 6));
            step();
        end
        wait_tiles(d0 + 2, "drain_two_tiles");

        // Three back-to-back tiles: next every 16 cycles.
        do_reset();
        n0 = next_t.size(); d0 = tiles_done; fft_ready = 1;
        for (int k = 0; k < 48; k++) begin
            in_valid = 1; in_data = 16'(200 + k);
            step();
        end
        in_valid = 0;
        wait_tiles(d0 + 3, "cont_three_tiles");
        chk("cont_next_count", next_t.size() - n0, 3);
        if (next_t.size() - n0 == 3) begin
            chk("cont_spacing_0", next_t[n0 + 1] - next_t[n0], 16);
            chk("cont_spacing_1", next_t[n0 + 2] - next_t[n0 + 1], 16);
        end

        // Random input gaps and FFT back-pressure over 10 tiles.
        d0 = tiles_done; acc = 0;
        for (int c = 0; c < 3000 && acc < 160; c++) begin
            in_valid  = ($urandom % 2) == 0;
            in_data   = 16'($urandom);
            fft_ready = ($urandom % 4) != 0;
            if (acc + int'(in_valid && in_ready) > 160) in_valid = 0;
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            step();
        end
        in_valid = 0; fft_ready = 1;
        chk("rand_accepted", acc, 160);
        wait_tiles(d0 + 10, "rand_ten_tiles");

        // Reset pulse in the middle of a stream.
        n0 = next_t.size();
        for (int k = 0; k < 16; k++) begin
            in_valid = 1; in_data = 16'(300 + k);
            step();
        end
        in_valid = 0;
        seen = 0;
        for (int c = 0; c < 20 && seen < 2; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
            step();
        end
        chk("mid_reset_saw_two_cols", seen, 2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_reset_out_valid", out_valid, 1'b0);
        chk("mid_reset_in_ready", in_ready, 1'b1);
        n0 = next_t.size(); d0 = tiles_done;
        repeat (8) begin
            @(negedge clk);
            chk("mid_reset_quiet_ovld", out_valid, 1'b0);
            step();
        end
        chk("mid_reset_no_next", next_t.size(), n0);
        chk("mid_reset_no_tile", tiles_done, d0);
        for (int k = 0; k < 16; k++) begin
            in_valid = 1; in_data = 16'(400 + 3*k);
            step();
        end
        in_valid = 0;
        wait_tiles(d0 + 1, "mid_reset_fresh_tile");

        // 16x16 tile on the wide instance.
        fft_ready16 = 1;
        for (int k = 0; k < 256; k++) begin
            in_valid16 = 1; in_data16 = 16'(k);
            step();
        end
        in_valid16 = 0;
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            @(negedge clk);
            if (nxt16) seen = 1;
            step();
        end
        chk("w16_next_seen", seen, 1);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            for (int i = 0; i < 16; i++) e16[i*16 +: 16] = 16'(16*i + c);
            chk($sformatf("w16_out_valid[%0d]", c), out_valid16, 1'b1);
            chk($sformatf("w16_column[%0d]", c), out_data16, e16);
            step();
        end
        @(negedge clk);
        chk("w16_end_out_valid", out_valid16, 1'b0);
        chk("w16_end_out_data", out_data16, 256'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fft_tile_loader.md
FFT_TILE_LOADER -- requirements
Module: fft_tile_loader

Interface
REQ-001 Parameter WIDTH, default 4, meaning tile edge length; legal values 4, 8 and 16; any other value SHALL raise $fatal at elaboration.
REQ-002 Parameter DATA_W, default 16, meaning sample width in bits (signed real sample).
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 in_valid  input  1  the upstream sample is valid this cycle.
REQ-006 in_ready  output  1  the block accepts a sample this cycle.
REQ-007 in_data  input  DATA_W  pixel sample; tiles arrive in row-major order.
REQ-008 fft_ready  input  1  the downstream 2D FFT can accept a new tile start.
REQ-009 next  output  1  one-cycle tile-start pulse to the 2D FFT.
REQ-010 out_data  output  WIDTH*DATA_W  lane i carries the row-i sample of the current column.
REQ-011 out_valid  output  1  out_data holds a tile column this cycle.

Function
REQ-012 A sample SHALL transfer only in a cycle where in_valid and in_ready are both 1.
REQ-013 Storage SHALL be two ping-pong banks of WIDTH x WIDTH samples; each bank SHALL have a full flag.
REQ-014 A write pointer SHALL address the fill bank, count row-major 0..WIDTH*WIDTH-1, and wrap to 0 on the last sample.
REQ-015 On the last sample of a tile, the fill bank SHALL be marked full and the fill bank SHALL toggle.
REQ-016 in_ready SHALL be 1 exactly when the current fill bank is not full.
REQ-017 The read FSM SHALL have three states: IDLE, START and STREAM.
REQ-018 IDLE -> START SHALL occur when the read bank is full and fft_ready=1; otherwise the FSM SHALL remain in IDLE.
REQ-019 In START, next=1 for exactly one cycle, then the FSM SHALL go to STREAM unconditionally.
REQ-020 In STREAM, column counter c=0..WIDTH-1 SHALL advance one per cycle; out_valid=1; lane i of out_data = bank[i][c].
REQ-021 out_data and out_valid SHALL be registered outputs.
REQ-022 On the c=WIDTH-1 cycle, the read bank SHALL be cleared to not full, the read bank SHALL toggle, and the FSM SHALL go to IDLE.
REQ-023 In STREAM, fft_ready SHALL be ignored; a tile stream is never paused.
REQ-024 Latency: last sample accepted at cycle t, with FSM in IDLE and fft_ready=1 -> next at t+1 and column 0 at t+2.
REQ-025 Consecutive next pulses SHALL be at least WIDTH+2 cycles apart.
REQ-026 Simultaneous write and read of different banks SHALL be supported at full rate.
REQ-027 When a bank is freed in the same cycle the writer stalls on it, in_ready SHALL rise on the following cycle, not the same cycle.
REQ-028 When out_valid=0, out_data SHALL be held at 0.
REQ-029 Sustained throughput SHALL be one tile per WIDTH*WIDTH input cycles; input-limited, no bubbles caused by the reader.

Reset
REQ-030 While reset=0 at a clock edge: both full flags=0; write pointer=0; fill bank=read bank=bank 0; FSM=IDLE.
REQ-031 Output values under reset SHALL be: next=0, out_valid=0, out_data=0.
REQ-032 in_ready SHALL be 1 from the first cycle after reset is released.
REQ-033 Reset asserted mid-fill or mid-stream SHALL discard all partial and full tiles; no next pulse or stream SHALL resume after release.
REQ-034 Bank contents need not be cleared by reset.

Verification
REQ-035 WIDTH=4, fft_ready=1, in_valid=1 streaming 0..15 -> next at the cycle after sample 15 is accepted; columns then appear on out_data as lanes {0,4,8,12}, {1,5,9,13}, {2,6,10,14}, {3,7,11,15}; out_valid=1 for exactly 4 cycles.
REQ-036 fft_ready=0 while 32 samples arrive -> both banks full, in_ready=0 after the 32nd sample, no next; raise fft_ready -> two tiles stream in order, and in_ready=1 again after the first stream ends.
REQ-037 Continuous input for 3 tiles with fft_ready=1 -> 3 next pulses spaced exactly 16 cycles apart; no sample lost or duplicated.
REQ-038 Random in_valid gaps (about 50%) over 10 tiles -> each output column matches the transposed reference tile.
REQ-039 reset=0 for one cycle during a stream after column 1 -> out_valid=0 on the next cycle, no further columns, in_ready=1; the next fresh tile of 16 samples produces a correct stream.
REQ-040 WIDTH=16: a 256-sample tile -> next, then 16 columns where lane i of column c equals sample 16*i+c.
